// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 3-stage pipeline.
//
// Owns the program counter, issues in-order word fetches to instruction memory
// over a valid/ready handshake and buffers returned instructions for decode.
// A taken branch or jump from execute redirects the PC. Requests already in
// flight at that moment stay counted, and their responses are dropped because
// they carry the old epoch bit.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   take_branch      taken conditional branch (execute)
//   jump             JAL/JALR resolved (execute)
//   target_pc        redirect target, low two bits ignored
//   stall            decode cannot accept this cycle
//   imem_req_*       request channel: valid/addr out, ready in
//   imem_resp_*      in-order response channel: valid/data in
//   if_valid/instr/pc  buffer head presented to decode
//   flush            kill the instruction currently in decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        take_branch,
  input  logic        jump,
  input  logic [31:0] target_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Control state
  logic [31:0]   fetch_pc;
  logic          epoch;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] occ;
  logic [AW-1:0] tag_wr, tag_rd;
  logic [AW-1:0] buf_wr, buf_rd;

  // Data storage (not reset; only entries covered by occ/out_cnt are read)
  logic          tag_ep    [BUF_DEPTH];
  logic [31:0]   tag_pc    [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];

  logic redirect;
  logic credit_ok;
  logic req_fire;
  logic resp_fire;
  logic resp_keep;
  logic pop;

  always_comb begin
    redirect  = take_branch | jump;
    // Outstanding requests plus buffered entries may never exceed the buffer,
    // so every response always has a slot waiting for it.
    credit_ok = ({1'b0, occ} + {1'b0, out_cnt}) < (CW+1)'(BUF_DEPTH);

    imem_req_valid = !rst && !redirect && credit_ok;
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding belongs to a request issued before
    // the last reset and is ignored.
    resp_fire = imem_resp_valid && (out_cnt != '0);
    resp_keep = resp_fire && !redirect && (tag_ep[tag_rd] == epoch);

    if_valid = (occ != '0) && !redirect;
    if_instr = (occ != '0) ? buf_instr[buf_rd] : 32'h0;
    if_pc    = (occ != '0) ? buf_pc[buf_rd]    : 32'h0;
    pop      = if_valid && !stall;

    flush = redirect;
  end

  // ---- stage boundary: control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
      out_cnt  <= '0;
      occ      <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
    end else begin
      if (req_fire)  tag_wr <= tag_wr + AW'(1);
      if (resp_fire) tag_rd <= tag_rd + AW'(1);
      out_cnt <= out_cnt + CW'(req_fire) - CW'(resp_fire);

      if (redirect) begin
        fetch_pc <= target_pc & 32'hFFFF_FFFC;
        epoch    <= ~epoch;
        occ      <= '0;
        buf_wr   <= '0;
        buf_rd   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        occ <= occ + CW'(resp_keep) - CW'(pop);
        if (resp_keep) buf_wr <= buf_wr + AW'(1);
        if (pop)       buf_rd <= buf_rd + AW'(1);
      end
    end
  end

  // ---- stage boundary: tag and instruction storage ----
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_ep[tag_wr] <= epoch;
      tag_pc[tag_wr] <= fetch_pc;
    end
    if (resp_keep) begin
      buf_pc[buf_wr]    <= tag_pc[tag_rd];
      buf_instr[buf_wr] <= imem_resp_data;
    end
  end

endmodule
